// File: rtl/ledpanel_pkg.sv
// Shared types and constants for the LED panel writer.
// The FILL state exists only when LEDPANEL_WRITER_FILL_EN is defined.
package ledpanel_pkg;

`ifdef LEDPANEL_WRITER_FILL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_FILL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1} state_t;
`endif

  // Byte lanes R, G, B written; lane 3 unused.
  localparam logic [3:0] CTRL_WR_RGB = 4'b0111;

  // Width of the x coordinate for a chain of 64-pixel-wide panels.
  function automatic int x_width(input int chained);
    return 6 + $clog2(chained);
  endfunction

endpackage

// File: rtl/ledpanel_addr_gen.sv
// Raster x/y counter shared by the stream and fill paths.
// addr/last describe the pixel written by the current step; restart forces
// that pixel to (0,0) (or just clears the counter when there is no step).
module ledpanel_addr_gen
  import ledpanel_pkg::*;
#(
  parameter int CHAINED = 1
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rstn,
  input  logic        step,
  input  logic        restart,
  output logic [15:0] addr,
  output logic        last
);

  localparam int XW = x_width(CHAINED);
  localparam logic [XW-1:0] X_MAX = XW'(64 * CHAINED - 1);

  logic [XW-1:0] x_q, x_cur;
  logic [5:0]    y_q, y_cur;

  // Position of the pixel this cycle would write.
  always_comb begin
    x_cur = restart ? '0 : x_q;
    y_cur = restart ? '0 : y_q;
  end

  assign last = (x_cur == X_MAX) && (y_cur == 6'd63);
  assign addr = 16'({y_cur, x_cur});

  // Advance in raster order; y wraps naturally after row 63.
  always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
    if (!ctrl_rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step) begin
      if (x_cur == X_MAX) begin
        x_q <= '0;
        y_q <= y_cur + 6'd1;
      end else begin
        x_q <= x_cur + 1'b1;
        y_q <= y_cur;
      end
    end else if (restart) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

endmodule

// File: rtl/ledpanel_writer.sv
// LED panel frame writer: turns a pixel stream (or a solid-colour fill)
// into registered video-memory writes in raster order.
// Optional fill feature: define LEDPANEL_WRITER_FILL_EN.
module ledpanel_writer
  import ledpanel_pkg::*;
#(
  parameter int CHAINED     = 1,
  parameter int INPUT_DEPTH = 6
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        fill_req,
  input  logic [23:0] fill_color,
  output logic        fill_busy,
  output logic        ctrl_en,
  output logic [3:0]  ctrl_wr,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic        frame_done,
  output logic        err_sync,
  output logic [15:0] frame_cnt
);

  state_t        state_q, state_d;
  logic          step, restart, wen, err_d, done_d, last;
  logic [23:0]   wr_d;
  logic [15:0]   gen_addr;

  ledpanel_addr_gen #(.CHAINED(CHAINED)) u_addr_gen (
    .ctrl_clk  (ctrl_clk),
    .ctrl_rstn (ctrl_rstn),
    .step      (step),
    .restart   (restart),
    .addr      (gen_addr),
    .last      (last)
  );

`ifdef LEDPANEL_WRITER_FILL_EN
  logic        busy_d;
  logic [23:0] fill_q;
`endif

  // Next state, write request and event pulses.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    restart = 1'b0;
    wen     = 1'b0;
    wr_d    = s_data;
    err_d   = 1'b0;
    done_d  = 1'b0;
    s_ready = 1'b1;
`ifdef LEDPANEL_WRITER_FILL_EN
    busy_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef LEDPANEL_WRITER_FILL_EN
        // A fill request wins; the concurrent beat is refused.
        if (fill_req) begin
          s_ready = 1'b0;
          restart = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_FILL;
        end else
`endif
        if (s_valid) begin
          if (s_sof) begin
            wen     = 1'b1;
            step    = 1'b1;
            restart = 1'b1;
            state_d = ST_STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (s_valid) begin
          wen  = 1'b1;
          step = 1'b1;
          if (s_sof) begin
            // Unexpected start of frame: resynchronise on it.
            err_d   = 1'b1;
            restart = 1'b1;
          end else if (last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef LEDPANEL_WRITER_FILL_EN
      ST_FILL: begin
        s_ready = 1'b0;
        busy_d  = 1'b1;
        wen     = 1'b1;
        step    = 1'b1;
        wr_d    = fill_q;
        if (last) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered write bus; address/data hold between writes.
  always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
    if (!ctrl_rstn) begin
      state_q    <= ST_IDLE;
      ctrl_en    <= 1'b0;
      ctrl_wr    <= 4'b0;
      ctrl_addr  <= 16'b0;
      ctrl_wdat  <= 24'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
      frame_cnt  <= 16'b0;
    end else begin
      state_q    <= state_d;
      ctrl_en    <= wen;
      frame_done <= done_d;
      err_sync   <= err_d;
      if (wen) begin
        ctrl_wr   <= CTRL_WR_RGB;
        ctrl_addr <= gen_addr;
        ctrl_wdat <= wr_d;
      end
      if (done_d) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef LEDPANEL_WRITER_FILL_EN
  // Fill colour captured on entry; busy covers the final write's cycle too.
  always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
    if (!ctrl_rstn) begin
      fill_busy <= 1'b0;
      fill_q    <= 24'b0;
    end else begin
      fill_busy <= busy_d;
      if (state_q == ST_IDLE && fill_req) fill_q <= fill_color;
    end
  end

  logic unused_ok;
  assign unused_ok = (INPUT_DEPTH > 0);
`else
  assign fill_busy = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{fill_req, fill_color, (INPUT_DEPTH > 0)};
`endif

endmodule

// File: tb/tb_ledpanel_writer.sv
// Bench for ledpanel_writer: CHAINED=1 and CHAINED=2 instances share one
// stimulus stream; a linear-index pixel model predicts every output.
module tb_ledpanel_writer;

`ifdef LEDPANEL_WRITER_FILL_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic ctrl_clk = 1'b0;
  logic ctrl_rstn = 1'b0;
  logic s_valid = 1'b0, s_sof = 1'b0, fill_req = 1'b0;
  logic [23:0] s_data = '0, fill_color = '0;

  logic [1:0]       s_ready, fill_busy, ctrl_en, frame_done, err_sync;
  logic [1:0][3:0]  ctrl_wr;
  logic [1:0][15:0] ctrl_addr, frame_cnt;
  logic [1:0][23:0] ctrl_wdat;

  always #5 ctrl_clk = ~ctrl_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ledpanel_writer #(.CHAINED(g + 1), .INPUT_DEPTH(6)) u_dut (
      .ctrl_clk   (ctrl_clk),
      .ctrl_rstn  (ctrl_rstn),
      .s_valid    (s_valid),
      .s_ready    (s_ready[g]),
      .s_data     (s_data),
      .s_sof      (s_sof),
      .fill_req   (fill_req),
      .fill_color (fill_color),
      .fill_busy  (fill_busy[g]),
      .ctrl_en    (ctrl_en[g]),
      .ctrl_wr    (ctrl_wr[g]),
      .ctrl_addr  (ctrl_addr[g]),
      .ctrl_wdat  (ctrl_wdat[g]),
      .frame_done (frame_done[g]),
      .err_sync   (err_sync[g]),
      .frame_cnt  (frame_cnt[g])
    );
  end

  int errors = 0;
  int checks = 0;

  // Model: mode 0 idle, 1 streaming, 2 filling; idx = linear pixel index.
  int          m_mode [2];
  int          m_idx  [2];
  logic [23:0] m_fcol [2];
  logic        m_en   [2];
  logic        m_done [2];
  logic        m_err  [2];
  logic        m_busy [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_cnt  [2];
  logic [23:0] m_wdat [2];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[ch%0d] got %0h want %0h at %0t", nm, g + 1, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] raster(input int g, input int i);
    int w, xw;
    w  = 64 * (g + 1);
    xw = 6 + $clog2(g + 1);
    return 16'(((i / w) << xw) | (i % w));
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_mode[g] = 0; m_idx[g] = 0; m_fcol[g] = '0;
      m_en[g] = 0; m_done[g] = 0; m_err[g] = 0; m_busy[g] = 0;
      m_addr[g] = '0; m_cnt[g] = '0; m_wdat[g] = '0;
    end
  endtask

  task automatic put(input int g, input int i, input logic [23:0] d);
    m_en[g] = 1'b1; m_addr[g] = raster(g, i); m_wdat[g] = d;
  endtask

  // Outputs expected after the coming rising edge.
  task automatic model_step();
    for (int g = 0; g < 2; g++) begin
      int mem;
      mem = 4096 * (g + 1);
      if (!ctrl_rstn) begin
        m_mode[g] = 0; m_idx[g] = 0; m_en[g] = 0; m_done[g] = 0; m_err[g] = 0;
        m_busy[g] = 0; m_addr[g] = '0; m_cnt[g] = '0; m_wdat[g] = '0;
      end else begin
        m_en[g] = 0; m_done[g] = 0; m_err[g] = 0; m_busy[g] = 0;
        case (m_mode[g])
          0: begin
            if (FE && fill_req) begin
              m_mode[g] = 2; m_fcol[g] = fill_color; m_idx[g] = 0; m_busy[g] = 1;
            end else if (s_valid) begin
              if (s_sof) begin put(g, 0, s_data); m_idx[g] = 1; m_mode[g] = 1; end
              else m_err[g] = 1;
            end
          end
          1: begin
            if (s_valid) begin
              if (s_sof) begin
                m_err[g] = 1; put(g, 0, s_data); m_idx[g] = 1;
              end else begin
                put(g, m_idx[g], s_data);
                if (m_idx[g] == mem - 1) begin
                  m_done[g] = 1; m_cnt[g] = m_cnt[g] + 16'd1; m_mode[g] = 0; m_idx[g] = 0;
                end else m_idx[g]++;
              end
            end
          end
          default: begin
            put(g, m_idx[g], m_fcol[g]); m_busy[g] = 1;
            if (m_idx[g] == mem - 1) begin m_mode[g] = 0; m_idx[g] = 0; end
            else m_idx[g]++;
          end
        endcase
      end
    end
  endtask

  task automatic compare();
    for (int g = 0; g < 2; g++) begin
      logic rdy;
      rdy = (m_mode[g] != 2) && !(FE && m_mode[g] == 0 && fill_req);
      chk("ctrl_en", g, ctrl_en[g], m_en[g]);
      chk("ctrl_addr", g, ctrl_addr[g], m_addr[g]);
      chk("ctrl_wdat", g, ctrl_wdat[g], m_wdat[g]);
      if (m_en[g]) chk("ctrl_wr", g, ctrl_wr[g], 4'b0111);
      chk("frame_done", g, frame_done[g], m_done[g]);
      chk("err_sync", g, err_sync[g], m_err[g]);
      chk("frame_cnt", g, frame_cnt[g], m_cnt[g]);
      chk("fill_busy", g, fill_busy[g], m_busy[g]);
      chk("s_ready", g, s_ready[g], rdy);
    end
  endtask

  // One clock: drive, check settled outputs, advance model, pass the edge.
  task automatic cycle(input logic v, input logic sof, input logic [23:0] d, input logic fr);
    s_valid = v; s_sof = sof; s_data = d; fill_req = fr;
    #2;
    compare();
    model_step();
    @(negedge ctrl_clk);
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 7) == 0)
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom), 24'($urandom), 1'b0);
  endtask

  task automatic all_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk({nm, "_en"}, g, ctrl_en[g], 0);
      chk({nm, "_wr"}, g, ctrl_wr[g], 0);
      chk({nm, "_addr"}, g, ctrl_addr[g], 0);
      chk({nm, "_wdat"}, g, ctrl_wdat[g], 0);
      chk({nm, "_cnt"}, g, frame_cnt[g], 0);
      chk({nm, "_err"}, g, err_sync[g], 0);
      chk({nm, "_done"}, g, frame_done[g], 0);
      chk({nm, "_busy"}, g, fill_busy[g], 0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge ctrl_clk);
    repeat (3) cycle(1'b1, 1'b1, 24'h777777, 1'b0);
    all_zero("reset");
    ctrl_rstn = 1'b1;
    cycle(1'b0, 1'b0, 24'h0, 1'b0);

    // Beat without start-of-frame while idle: dropped, error pulse.
    cycle(1'b1, 1'b0, 24'h123456, 1'b0);
    for (int g = 0; g < 2; g++) begin
      chk("nosof_en", g, ctrl_en[g], 0);
      chk("nosof_err", g, err_sync[g], 1);
    end
    cycle(1'b0, 1'b0, 24'h0, 1'b0);
    chk("nosof_err_pulse", 0, err_sync[0], 0);

    // 8192-beat frame: full frame for CHAINED=2, frame + overrun for CHAINED=1.
    for (int i = 0; i < 8192; i++) begin
      maybe_gap();
      cycle(1'b1, i == 0, 24'(i), 1'b0);
      if (i == 64)  chk("beat64_addr", 1, ctrl_addr[1], 16'h0040);
      if (i == 128) chk("beat128_addr", 1, ctrl_addr[1], 16'h0080);
      if (i == 4095) begin
        chk("f1_last_addr", 0, ctrl_addr[0], 16'h0FFF);
        chk("f1_last_wdat", 0, ctrl_wdat[0], 24'h000FFF);
        chk("f1_done", 0, frame_done[0], 1);
        chk("f1_cnt", 0, frame_cnt[0], 1);
      end
      if (i == 4096) chk("f1_overrun_err", 0, err_sync[0], 1);
      if (i == 8191) begin
        chk("f2_last_addr", 1, ctrl_addr[1], 16'h1FFF);
        chk("f2_done", 1, frame_done[1], 1);
        chk("f2_cnt", 1, frame_cnt[1], 1);
      end
    end

    // Start-of-frame reasserted on beat 100 restarts at address 0.
    for (int i = 0; i < 4196; i++) begin
      maybe_gap();
      cycle(1'b1, (i == 0) || (i == 100), 24'(i) ^ 24'hA5A5A5, 1'b0);
      if (i == 100) begin
        chk("resof_err", 0, err_sync[0], 1);
        chk("resof_en", 0, ctrl_en[0], 1);
        chk("resof_addr", 0, ctrl_addr[0], 16'h0000);
        chk("resof_addr", 1, ctrl_addr[1], 16'h0000);
      end
      if (i == 4195) begin
        chk("resof_done", 0, frame_done[0], 1);
        chk("resof_cnt", 0, frame_cnt[0], 2);
      end
    end

    // Asynchronous reset after beat 2000, mid-cycle.
    for (int i = 0; i <= 2000; i++) cycle(1'b1, i == 0, 24'($urandom), 1'b0);
    #3 ctrl_rstn = 1'b0;
    #1 all_zero("async_rst");
    model_reset();
    @(negedge ctrl_clk);
    ctrl_rstn = 1'b1;
    cycle(1'b1, 1'b0, 24'h010203, 1'b0);
    chk("post_rst_nosof_en", 0, ctrl_en[0], 0);
    chk("post_rst_nosof_err", 0, err_sync[0], 1);
    cycle(1'b1, 1'b1, 24'hABCDEF, 1'b0);
    chk("post_rst_addr", 0, ctrl_addr[0], 16'h0000);
    chk("post_rst_wdat", 1, ctrl_wdat[1], 24'hABCDEF);

    // Random traffic including spurious start-of-frame and fill requests.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, 24'($urandom),
            FE && ($urandom_range(0, 499) == 0));

`ifdef LEDPANEL_WRITER_FILL_EN
    #3 ctrl_rstn = 1'b0;
    model_reset();
    @(negedge ctrl_clk);
    ctrl_rstn = 1'b1;
    fill_color = 24'h3F003F;
    cycle(1'b1, 1'b1, 24'h111111, 1'b1);
    chk("fill_entry_en", 0, ctrl_en[0], 0);
    fill_color = 24'h000000;
    for (int k = 0; k < 8200; k++) begin
      cycle(k < 4096, 1'($urandom), 24'($urandom), 1'b0);
      if (k == 0) chk("fill_first_wdat", 0, ctrl_wdat[0], 24'h3F003F);
      if (k == 4095) begin
        chk("fill_last_addr", 0, ctrl_addr[0], 16'h0FFF);
        chk("fill_last_busy", 0, fill_busy[0], 1);
      end
      if (k == 4096) begin
        chk("fill_end_en", 0, ctrl_en[0], 0);
        chk("fill_end_busy", 0, fill_busy[0], 0);
        chk("fill_cnt", 0, frame_cnt[0], 0);
      end
    end
`endif

    cycle(1'b0, 1'b0, 24'h0, 1'b0);
    #2 compare();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
